// File: rtl/sips4_pkg.sv
// Shared definitions for the SIPS4 decode stage: opcode encoding, instruction
// field positions, default widths and small opcode-class helpers.
package sips4_pkg;

  localparam int DW_DEF  = 4;
  localparam int AW_DEF  = 3;

  localparam int OP_LSB  = 12;
  localparam int RD_LSB  = 9;
  localparam int RS_LSB  = 6;
  localparam int RT_LSB  = 3;
  localparam int IMM_LSB = 0;
  localparam int OP_W    = 4;
  localparam int REG_W   = 3;
  localparam int IMM_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'd0,
    OP_ADD  = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_ADDI = 4'd5,
    OP_LI   = 4'd6,
    OP_HALT = 4'd15
  } op_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op <= OP_LI) || (op == OP_HALT);
  endfunction

  function automatic logic op_writes(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_LI);
  endfunction

  function automatic logic op_uses_rt(input logic [OP_W-1:0] op);
    return (op >= OP_ADD) && (op <= OP_OR);
  endfunction

  function automatic logic op_uses_imm(input logic [OP_W-1:0] op);
    return (op == OP_ADDI) || (op == OP_LI);
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch, register-file, writeback and execute signals of the decode stage.
// slave = decode stage side, master = surrounding pipeline side.
interface decode_stage_if
  import sips4_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_instr;
  logic [AW-1:0] rf_ra1;
  logic [AW-1:0] rf_ra2;
  logic [DW-1:0] rf_rd1;
  logic [DW-1:0] rf_rd2;
  logic          wb_we;
  logic [AW-1:0] wb_wa;
  logic [DW-1:0] wb_wd;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_op;
  logic [AW-1:0] out_wa;
  logic          out_we;
  logic [DW-1:0] out_a;
  logic [DW-1:0] out_b;

  modport slave (
    input  in_valid, in_instr, rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd, out_ready,
    output in_ready, rf_ra1, rf_ra2, out_valid, out_op, out_wa, out_we, out_a, out_b
  );

  modport master (
    output in_valid, in_instr, rf_rd1, rf_rd2, wb_we, wb_wa, wb_wd, out_ready,
    input  in_ready, rf_ra1, rf_ra2, out_valid, out_op, out_wa, out_we, out_a, out_b
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue
// of a writing instruction, cleared on writeback; a same-cycle set wins.
module reg_scoreboard
  import sips4_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_set,
  input  logic [AW-1:0] i_set_addr,
  input  logic          i_clr,
  input  logic [AW-1:0] i_clr_addr,
  input  logic [AW-1:0] i_src1,
  input  logic [AW-1:0] i_src2,
  output logic          o_pend1,
  output logic          o_pend2
);
  localparam int NREG = 1 << AW;

  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_pend_nxt;

  // Clear applied before set so an issue to the register being written back stays pending.
  always_comb begin
    w_pend_nxt = r_pend;
    if (i_clr) w_pend_nxt[i_clr_addr] = 1'b0;
    if (i_set) w_pend_nxt[i_set_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_pend <= '0;
    else        r_pend <= w_pend_nxt;
  end

  assign o_pend1 = r_pend[i_src1];
  assign o_pend2 = r_pend[i_src2];
endmodule

// File: rtl/decode_stage.sv
// SIPS4 decode stage: decodes one instruction per cycle into a registered
// execute payload with scoreboard hazard stalls and a RUN/HALTED FSM.
// Optional macro DECODE_BYPASS_EN forwards same-cycle writeback data into operands.
module decode_stage
  import sips4_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic resume,
  output logic halted,
  output logic illegal,
  decode_stage_if.slave bus
);
  state_e          r_state;
  state_e          w_state_nxt;
  logic            r_vld_p1;
  logic [3:0]      r_op_p1;
  logic [AW-1:0]   r_wa_p1;
  logic            r_we_p1;
  logic [DW-1:0]   r_a_p1;
  logic [DW-1:0]   r_b_p1;
  logic            r_illegal;

  logic [3:0]      w_op;
  logic [AW-1:0]   w_rd;
  logic [AW-1:0]   w_rs;
  logic [AW-1:0]   w_rt;
  logic [DW-1:0]   w_imm_ext;
  logic            w_pend_rs;
  logic            w_pend_rt;
  logic            w_fwd_rs;
  logic            w_fwd_rt;
  logic [DW-1:0]   w_rs_val;
  logic [DW-1:0]   w_rt_val;
  logic [DW-1:0]   w_a;
  logic [DW-1:0]   w_b;
  logic [3:0]      w_op_dec;
  logic            w_we_dec;
  logic            w_hazard;
  logic            w_run;
  logic            w_in_ready;
  logic            w_accept;

  assign w_op      = bus.in_instr[OP_LSB +: OP_W];
  assign w_rd      = AW'(bus.in_instr[RD_LSB +: REG_W]);
  assign w_rs      = AW'(bus.in_instr[RS_LSB +: REG_W]);
  assign w_rt      = AW'(bus.in_instr[RT_LSB +: REG_W]);
  assign w_imm_ext = DW'(bus.in_instr[IMM_LSB +: IMM_W]);

  assign bus.rf_ra1 = w_rs;
  assign bus.rf_ra2 = w_rt;

`ifdef DECODE_BYPASS_EN
  assign w_fwd_rs = bus.wb_we && (bus.wb_wa == w_rs);
  assign w_fwd_rt = bus.wb_we && (bus.wb_wa == w_rt);
`else
  assign w_fwd_rs = 1'b0;
  assign w_fwd_rt = 1'b0;
  logic w_unused_wd;
  assign w_unused_wd = ^bus.wb_wd;
`endif

  assign w_rs_val = w_fwd_rs ? bus.wb_wd : bus.rf_rd1;
  assign w_rt_val = w_fwd_rt ? bus.wb_wd : bus.rf_rd2;

  // rs feeds out_a for every opcode except LI; illegal opcodes issue as NOP.
  assign w_a      = (w_op == OP_LI) ? '0 : w_rs_val;
  assign w_b      = op_uses_rt(w_op)  ? w_rt_val :
                    op_uses_imm(w_op) ? w_imm_ext : '0;
  assign w_op_dec = op_legal(w_op) ? w_op : OP_NOP;
  assign w_we_dec = op_writes(w_op);

  assign w_hazard   = ((w_op != OP_LI) && w_pend_rs && !w_fwd_rs) ||
                      (op_uses_rt(w_op) && w_pend_rt && !w_fwd_rt);
  assign w_run      = (r_state == ST_RUN);
  assign w_in_ready = w_run && !w_hazard && (!r_vld_p1 || bus.out_ready);
  assign w_accept   = bus.in_valid && w_in_ready;

  reg_scoreboard #(.AW(AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set      (w_accept && w_we_dec),
    .i_set_addr (w_rd),
    .i_clr      (bus.wb_we),
    .i_clr_addr (bus.wb_wa),
    .i_src1     (w_rs),
    .i_src2     (w_rt),
    .o_pend1    (w_pend_rs),
    .o_pend2    (w_pend_rt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:    if (w_accept && (w_op == OP_HALT)) w_state_nxt = ST_HALTED;
      ST_HALTED: if (resume) w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_illegal <= r_illegal || (w_accept && !op_legal(w_op));
    end
  end

  // Stage p1: execute payload, held stable while out_valid waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_op_p1  <= '0;
      r_wa_p1  <= '0;
      r_we_p1  <= 1'b0;
      r_a_p1   <= '0;
      r_b_p1   <= '0;
    end else if (w_accept) begin
      r_vld_p1 <= 1'b1;
      r_op_p1  <= w_op_dec;
      r_wa_p1  <= w_rd;
      r_we_p1  <= w_we_dec;
      r_a_p1   <= w_a;
      r_b_p1   <= w_b;
    end else if (bus.out_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_vld_p1;
  assign bus.out_op    = r_op_p1;
  assign bus.out_wa    = r_wa_p1;
  assign bus.out_we    = r_we_p1;
  assign bus.out_a     = r_a_p1;
  assign bus.out_b     = r_b_p1;
  assign halted        = (r_state == ST_HALTED);
  assign illegal       = r_illegal;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations plus randomized traffic compared every cycle to a reference model.
module tb_decode_stage;
  localparam int DW = 4;
  localparam int AW = 3;
`ifdef DECODE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]    op;
    logic [AW-1:0] wa;
    logic          we;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } out_t;

  logic clk = 1'b0;
  logic rst_n;
  logic resume;
  logic halted;
  logic illegal;
  int   n_chk = 0;
  int   n_err = 0;

  decode_stage_if #(.DW(DW), .AW(AW)) bus ();

  decode_stage #(.DW(DW), .AW(AW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .resume  (resume),
    .halted  (halted),
    .illegal (illegal),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Register file owned by the bench; reads are combinational
  logic [DW-1:0] rf [8];
  assign bus.rf_rd1 = rf[bus.rf_ra1];
  assign bus.rf_rd2 = rf[bus.rf_ra2];
  always @(posedge clk) if (bus.wb_we) rf[bus.wb_wa] <= bus.wb_wd;

  // Reference model state
  logic          m_vld, m_halt, m_ill;
  out_t          m_out, m_next;
  logic [7:0]    m_pend, m_pend_nxt;
  logic          m_rdy, m_acc, m_bad;
  logic [3:0]    t_op, t_imm;
  logic [2:0]    t_rd, t_rs, t_rt;
  logic          t_fa, t_fb, t_need_a, t_need_b;
  logic [DW-1:0] t_va, t_vb;

  always_comb begin
    t_op  = bus.in_instr[15:12];
    t_rd  = bus.in_instr[11:9];
    t_rs  = bus.in_instr[8:6];
    t_rt  = bus.in_instr[5:3];
    t_imm = bus.in_instr[3:0];
    t_fa  = BYP && bus.wb_we && (bus.wb_wa == t_rs);
    t_fb  = BYP && bus.wb_we && (bus.wb_wa == t_rt);
    t_va  = t_fa ? bus.wb_wd : rf[t_rs];
    t_vb  = t_fb ? bus.wb_wd : rf[t_rt];
    m_next = '0;
    m_next.wa = t_rd;
    t_need_a = 1'b1;
    t_need_b = 1'b0;
    m_bad = 1'b0;
    case (t_op)
      4'd1, 4'd2, 4'd3, 4'd4: begin
        m_next.op = t_op; m_next.a = t_va; m_next.b = t_vb; m_next.we = 1'b1; t_need_b = 1'b1;
      end
      4'd5: begin m_next.op = t_op; m_next.a = t_va; m_next.b = t_imm; m_next.we = 1'b1; end
      4'd6: begin m_next.op = t_op; m_next.a = '0; m_next.b = t_imm; m_next.we = 1'b1; t_need_a = 1'b0; end
      4'd0, 4'd15: begin m_next.op = t_op; m_next.a = t_va; end
      default: begin m_next.a = t_va; m_bad = 1'b1; end
    endcase
    m_rdy = !m_halt && !(t_need_a && m_pend[t_rs] && !t_fa) &&
            !(t_need_b && m_pend[t_rt] && !t_fb) && (!m_vld || bus.out_ready);
    m_acc = bus.in_valid && m_rdy;
    m_pend_nxt = m_pend;
    if (bus.wb_we) m_pend_nxt[bus.wb_wa] = 1'b0;
    if (m_acc && m_next.we) m_pend_nxt[t_rd] = 1'b1;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= 1'b0; m_out <= '0; m_pend <= '0; m_halt <= 1'b0; m_ill <= 1'b0;
    end else begin
      if (m_acc) begin m_vld <= 1'b1; m_out <= m_next; end
      else if (bus.out_ready) m_vld <= 1'b0;
      m_pend <= m_pend_nxt;
      m_halt <= m_halt ? !resume : (m_acc && t_op == 4'd15);
      m_ill  <= m_ill || (m_acc && m_bad);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      chk("mdl_in_ready",  32'(bus.in_ready),  32'(m_rdy));
      chk("mdl_out_valid", 32'(bus.out_valid), 32'(m_vld));
      chk("mdl_halted",    32'(halted),        32'(m_halt));
      chk("mdl_illegal",   32'(illegal),       32'(m_ill));
      chk("mdl_ra",        32'({bus.rf_ra1, bus.rf_ra2}), 32'({t_rs, t_rt}));
      if (m_vld) chk("mdl_payload",
                     32'({bus.out_op, bus.out_wa, bus.out_we, bus.out_a, bus.out_b}), 32'(m_out));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk_out(input string name, input logic [3:0] op, input logic [2:0] wa,
                         input logic we, input logic [3:0] a, input logic [3:0] b);
    chk({name, "_valid"}, 32'(bus.out_valid), 32'(1));
    chk({name, "_pay"}, 32'({bus.out_op, bus.out_wa, bus.out_we, bus.out_a, bus.out_b}),
        32'({op, wa, we, a, b}));
  endtask

  initial begin
    rst_n = 1'b0; resume = 1'b0;
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
    bus.wb_we = 1'b0; bus.wb_wa = '0; bus.wb_wd = '0;
    for (int i = 0; i < 8; i++) rf[i] = (i == 0) ? 4'd0 : 4'(i + 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs", 32'({bus.out_valid, bus.out_op, bus.out_wa, bus.out_we, bus.out_a, bus.out_b}), 32'(0));
    chk("rst_flags", 32'({halted, illegal}), 32'(0));
    rst_n = 1'b1;

    // ADD r1,r1,r2 with r1=3 r2=4
    tick(); bus.in_valid = 1'b1; bus.in_instr = 16'h1250; bus.out_ready = 1'b1;
    @(negedge clk); chk("add_ready", 32'(bus.in_ready), 32'(1));
    chk("add_ra", 32'({bus.rf_ra1, bus.rf_ra2}), 32'({3'd1, 3'd2}));
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); chk_out("add", 4'd1, 3'd1, 1'b1, 4'd3, 4'd4);
    tick(); bus.wb_we = 1'b1; bus.wb_wa = 3'd1; bus.wb_wd = 4'd7;

    // ADDI r2 then dependent ADD r3,r2,r2
    tick(); bus.wb_we = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 16'h5401;
    @(negedge clk); chk("addi_ready", 32'(bus.in_ready), 32'(1));
    tick(); bus.in_instr = 16'h1690;
    @(negedge clk); chk("haz_stall0", 32'(bus.in_ready), 32'(0));
    chk_out("addi", 4'd5, 3'd2, 1'b1, 4'd0, 4'd1);
    tick();
    @(negedge clk); chk("haz_stall1", 32'(bus.in_ready), 32'(0));
    tick(); bus.wb_we = 1'b1; bus.wb_wa = 3'd2; bus.wb_wd = 4'd9;
    @(negedge clk); chk("haz_wb_ready", 32'(bus.in_ready), 32'(BYP));
    tick(); bus.wb_we = 1'b0; bus.out_ready = 1'b0;
    @(negedge clk); chk("haz_issue_time", 32'(bus.out_valid), 32'(BYP));

    // Output stall: OR r4,r5,r6 waits behind the held ADD
    tick(); bus.in_instr = 16'h4970;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk_out("stall_hold", 4'd1, 3'd3, 1'b1, 4'd9, 4'd9);
      chk("stall_ready", 32'(bus.in_ready), 32'(0));
      tick();
    end
    bus.out_ready = 1'b1;
    @(negedge clk); chk("drain_ready", 32'(bus.in_ready), 32'(1));
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); chk_out("or", 4'd4, 3'd4, 1'b1, 4'd7, 4'd8);

    // HALT, then resume
    tick(); bus.in_valid = 1'b1; bus.in_instr = 16'hF000;
    @(negedge clk); chk("halt_ready", 32'(bus.in_ready), 32'(1));
    tick(); bus.in_instr = 16'h0000;
    @(negedge clk); chk("halted", 32'({halted, bus.in_ready}), 32'(2'b10));
    chk_out("halt", 4'd15, 3'd0, 1'b0, 4'd0, 4'd0);
    tick();
    @(negedge clk); chk("halted_hold", 32'({halted, bus.in_ready}), 32'(2'b10));
    tick(); resume = 1'b1;
    @(negedge clk); chk("resume_pulse", 32'({halted, bus.in_ready}), 32'(2'b10));
    tick(); resume = 1'b0;
    @(negedge clk); chk("resumed", 32'({halted, bus.in_ready}), 32'(2'b01));
    tick(); bus.in_instr = 16'h9000;
    @(negedge clk); chk_out("nop", 4'd0, 3'd0, 1'b0, 4'd0, 4'd0);

    // Illegal opcode 9
    tick(); bus.in_instr = 16'h1250;
    @(negedge clk); chk_out("illegal_nop", 4'd0, 3'd0, 1'b0, 4'd0, 4'd0);
    chk("illegal_set", 32'(illegal), 32'(1));
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); chk("illegal_sticky", 32'({illegal, bus.out_op}), 32'({1'b1, 4'd1}));

    // LI r5,#3 held in a stalled output, then async reset
    tick(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_instr = 16'h6A03;
    @(negedge clk); chk("li_ready", 32'(bus.in_ready), 32'(1));
    tick(); bus.in_instr = 16'h0000;
    @(negedge clk); chk_out("li", 4'd6, 3'd5, 1'b1, 4'd0, 4'd3);
    chk("li_sb5", 32'(dut.u_sb.r_pend[5]), 32'(1));
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out", 32'({bus.out_valid, bus.out_op, bus.out_b, illegal}), 32'(0));
    chk("async_rst_sb", 32'(dut.u_sb.r_pend), 32'(0));
    #1 rst_n = 1'b1; bus.out_ready = 1'b1;
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); chk_out("post_rst", 4'd0, 3'd0, 1'b0, 4'd0, 4'd0);

    // Randomized traffic, checked by the per-cycle comparison
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] op;
      logic [2:0] start, pick;
      logic       found;
      tick();
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 6)) : 4'($urandom_range(0, 15));
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_instr  = {op, 12'($urandom)};
      bus.out_ready = ($urandom_range(0, 9) < 7);
      resume        = ($urandom_range(0, 7) == 0);
      bus.wb_we     = ($urandom_range(0, 9) < 4);
      start = 3'($urandom_range(0, 7));
      pick  = start;
      found = 1'b0;
      for (int k = 0; k < 8; k++)
        if (!found && m_pend[3'(start + 3'(k))]) begin pick = 3'(start + 3'(k)); found = 1'b1; end
      bus.wb_wa = pick;
      bus.wb_wd = 4'($urandom);
    end
    tick();
    bus.in_valid = 1'b0; bus.wb_we = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DW, 4, register data width.
REQ-002 Parameter AW, 3, register address width (8 registers).
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  fetch presents instruction.
REQ-006 in_instr  in  16  op[15:12], rd[11:9], rs[8:6], rt[5:3], imm[3:0].
REQ-007 in_ready  out  1  instruction accepted this cycle when in_valid && in_ready.
REQ-008 rf_ra1 / rf_ra2  out  AW  register-file read addresses, combinationally equal to rs / rt of in_instr.
REQ-009 rf_rd1 / rf_rd2  in  DW  register-file read data, combinational, same cycle.
REQ-010 wb_we, wb_wa, wb_wd  in  1/AW/DW  writeback port, also driving register-file write.
REQ-011 out_valid, out_ready  out/in  1  handshake to execute.
REQ-012 out_op 4, out_wa AW, out_we 1, out_a DW, out_b DW  out  decoded, registered instruction.
REQ-013 resume  in  1  single-cycle pulse leaving HALTED.
REQ-014 halted  out  1  high in HALTED; illegal  out  1  sticky illegal-opcode flag.

Function
REQ-015 Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 ADDI, 6 LI, 15 HALT; others illegal.
REQ-016 out_a = rs value (0 for LI); out_b = rt value for ADD/SUB/AND/OR, zero-extended imm for ADDI/LI.
REQ-017 out_we = 1 for opcodes 1-6, else 0; out_wa = rd.
REQ-018 Output register loads on accept; one-cycle latency from accept to out_valid.
REQ-019 out_valid holds with stable payload until out_valid && out_ready; no accept into a full, stalled stage.
REQ-020 in_ready = RUN && !hazard && (!out_valid || out_ready).
REQ-021 8-bit scoreboard: bit rd sets on accept with out_we=1; bit wb_wa clears on wb_we.
REQ-022 Same-cycle set and clear of one bit: set wins.
REQ-023 hazard = a used source (rs; rt only when out_b uses it) pending and not satisfied by REQ-024.
REQ-024 Source matching wb_wa with wb_we in the same cycle is satisfied: operand takes wb_wd, not rf data.
REQ-025 FSM RUN -> HALTED on accepting HALT; HALTED -> RUN on resume; resume in RUN ignored.
REQ-026 In HALTED in_ready=0; pending out_valid still drains; scoreboard still clears.
REQ-027 Illegal opcode: accepted, issued as NOP (out_we=0), illegal set until reset.

Reset
REQ-028 rst_n low asynchronously clears: out_valid=0, out_op=0, out_wa=0, out_we=0, out_a=0, out_b=0, scoreboard=0, state RUN, halted=0, illegal=0.
REQ-029 Reset mid-stall or mid-HALT discards in-flight instruction; first accept possible on first posedge after release.

Configuration
REQ-030 Macro DECODE_BYPASS_EN defined: REQ-024 forwarding compiled in.
REQ-031 DECODE_BYPASS_EN undefined: no forwarding; a pending source stalls until its scoreboard bit has cleared (one extra cycle after wb_we).

Structure
REQ-032 Package sips4_pkg holds opcode enum, instruction field bit positions, DW/AW defaults.
REQ-033 Sub-module reg_scoreboard holds pending bits, set/clear ports and two source lookups.

Verification
REQ-034 Reset, in_instr=0x1250 (ADD r1,r1,r2), rf r1=3 r2=4, out_ready=1 -> next cycle out_valid=1, out_op=1, out_a=3, out_b=4, out_we=1, out_wa=1.
REQ-035 ADDI r2 then ADD r3,r2,r2 back-to-back, no wb -> in_ready=0 for second until wb_we=1 wb_wa=2 wb_wd=9; with DECODE_BYPASS_EN accepted that cycle, out_a=out_b=9; without, one cycle later.
REQ-036 out_ready=0 for 3 cycles with out_valid=1 -> payload unchanged, in_ready=0; out_ready=1 -> drains, next instruction accepted same cycle.
REQ-037 HALT accepted -> halted=1, in_ready=0 with in_valid=1; resume pulse -> halted=0, accept next cycle.
REQ-038 Opcode 0x9 -> out_op=0, out_we=0, illegal=1, stays 1 across further instructions until rst_n low.
REQ-039 rst_n low while out_valid=1 and scoreboard bit 5 set -> out_valid=0, scoreboard clear immediately, without clock edge.
